// File: rtl/maze_wall_sense_if.sv
// Tile ROM port shared between a wall-sense block (master) and the maze
// tile ROM (slave). tile_data is the wall bit for the address presented
// on the previous clock.
interface maze_wall_sense_if;
  logic [10:0] tile_addr;
  logic        tile_data;

  modport master (output tile_addr, input tile_data);
  modport slave  (input tile_addr, output tile_data);
endinterface

// File: rtl/maze_wall_sense.sv
// maze_wall_sense: once per frame_clk rising edge, latches the ghost
// position/size, probes the maze tile ROM one pixel beyond each sprite
// edge and publishes registered Up/Down/Left/Right wall flags that hold
// until the next pass commits.
// Build option: define WALL_SENSE_CORNER_EN to probe both leading-edge
// corners of each side (eight probes, flag = OR of the pair) instead of
// the single edge-centre probe.
module maze_wall_sense #(
  parameter int TILE_COLS = 40,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [9:0]        GhostX,
  input  logic [9:0]        GhostY,
  input  logic [9:0]        GhostS,
  maze_wall_sense_if.master rom,
  output logic              UpWall,
  output logic              DownWall,
  output logic              LeftWall,
  output logic              RightWall,
  output logic              busy,
  output logic              done
);

`ifdef WALL_SENSE_CORNER_EN
  localparam int NPROBE = 8;
`else
  localparam int NPROBE = 4;
`endif
  localparam int IDX_W = $clog2(NPROBE);
  localparam logic [10:0] SW_L = 11'(SCREEN_W);
  localparam logic [10:0] SH_L = 11'(SCREEN_H);

  typedef enum logic [2:0] {IDLE, LATCH, PROBE, DRAIN, COMMIT} state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic frame_sync1, frame_sync2, frame_sync3;
  logic start;

  logic signed [10:0] gx_p0, gy_p0, gs_p0;
  logic signed [10:0] px [NPROBE];
  logic signed [10:0] py [NPROBE];
  logic [10:0] probe_addr_p1 [NPROBE];
  logic        probe_off_p1  [NPROBE];
  logic             vld_p2;
  logic [IDX_W-1:0] cap_idx_p2;
  logic             stg [NPROBE];
  logic             wall_u, wall_d, wall_l, wall_r;

  // Probe outside the visible screen (negative coordinates wrap to >= 1024).
  function automatic logic off_screen(input logic signed [10:0] x, input logic signed [10:0] y);
    return x[10] | y[10] | ($unsigned(x) >= SW_L) | ($unsigned(y) >= SH_L);
  endfunction

  // Tile ROM address for a (col,row) tile position.
  function automatic logic [10:0] tile_index(input logic [5:0] col, input logic [5:0] row);
    return 11'(int'(row) * TILE_COLS) + {5'b0, col};
  endfunction

  // frame_clk synchroniser plus edge register; preset high so a frame_clk
  // already high at reset release is not seen as an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_sync1 <= 1'b1;
      frame_sync2 <= 1'b1;
      frame_sync3 <= 1'b1;
    end else begin
      frame_sync1 <= frame_clk;
      frame_sync2 <= frame_sync1;
      frame_sync3 <= frame_sync2;
    end
  end

  assign start = frame_sync2 & ~frame_sync3;

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; start outside IDLE is dropped.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LATCH;
      LATCH:   state_nxt = PROBE;
      PROBE:   if (idx == IDX_W'(NPROBE - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: status and the ROM address of the probe being issued.
  always_comb begin
    busy          = (state != IDLE);
    done          = (state == COMMIT);
    rom.tile_addr = 11'd0;
    if (state == PROBE && !probe_off_p1[idx]) rom.tile_addr = probe_addr_p1[idx];
  end

  // Probe index counter and capture-valid flag (control, reset).
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      idx    <= '0;
      vld_p2 <= 1'b0;
    end else begin
      if (state == PROBE) idx <= idx + 1'b1;
      else                idx <= '0;
      vld_p2 <= (state == PROBE);
    end
  end

  // Probe coordinates from the captured ghost geometry.
  always_comb begin
`ifdef WALL_SENSE_CORNER_EN
    px[0] = gx_p0 - gs_p0;          py[0] = gy_p0 - gs_p0 - 11'sd1;
    px[1] = gx_p0 + gs_p0;          py[1] = gy_p0 - gs_p0 - 11'sd1;
    px[2] = gx_p0 - gs_p0;          py[2] = gy_p0 + gs_p0 + 11'sd1;
    px[3] = gx_p0 + gs_p0;          py[3] = gy_p0 + gs_p0 + 11'sd1;
    px[4] = gx_p0 - gs_p0 - 11'sd1; py[4] = gy_p0 - gs_p0;
    px[5] = gx_p0 - gs_p0 - 11'sd1; py[5] = gy_p0 + gs_p0;
    px[6] = gx_p0 + gs_p0 + 11'sd1; py[6] = gy_p0 - gs_p0;
    px[7] = gx_p0 + gs_p0 + 11'sd1; py[7] = gy_p0 + gs_p0;
`else
    px[0] = gx_p0;                  py[0] = gy_p0 - gs_p0 - 11'sd1;
    px[1] = gx_p0;                  py[1] = gy_p0 + gs_p0 + 11'sd1;
    px[2] = gx_p0 - gs_p0 - 11'sd1; py[2] = gy_p0;
    px[3] = gx_p0 + gs_p0 + 11'sd1; py[3] = gy_p0;
`endif
  end

  // p0: ghost capture on start; p1: per-probe address/off-screen in LATCH;
  // p2: ROM bit captured one clock after its address was issued.
  always_ff @(posedge Clk) begin
    if (state == IDLE && start) begin
      gx_p0 <= {1'b0, GhostX};
      gy_p0 <= {1'b0, GhostY};
      gs_p0 <= {1'b0, GhostS};
    end
    if (state == LATCH) begin
      for (int i = 0; i < NPROBE; i++) begin
        probe_addr_p1[i] <= tile_index(px[i][9:4], py[i][9:4]);
        probe_off_p1[i]  <= off_screen(px[i], py[i]);
      end
    end
    cap_idx_p2 <= idx;
    if (vld_p2) stg[cap_idx_p2] <= probe_off_p1[cap_idx_p2] | rom.tile_data;
  end

`ifdef WALL_SENSE_CORNER_EN
  assign wall_u = stg[0] | stg[1];
  assign wall_d = stg[2] | stg[3];
  assign wall_l = stg[4] | stg[5];
  assign wall_r = stg[6] | stg[7];
`else
  assign wall_u = stg[0];
  assign wall_d = stg[1];
  assign wall_l = stg[2];
  assign wall_r = stg[3];
`endif

  // Published flags: all four update together in COMMIT and hold otherwise.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      UpWall    <= 1'b0;
      DownWall  <= 1'b0;
      LeftWall  <= 1'b0;
      RightWall <= 1'b0;
    end else if (state == COMMIT) begin
      UpWall    <= wall_u;
      DownWall  <= wall_d;
      LeftWall  <= wall_l;
      RightWall <= wall_r;
    end
  end

endmodule
